// File: rtl/blake_round_if.sv
// Handshake and control bundle between the BLAKE-512 round controller and its
// environment: the padder, the round counter/datapath and the digest consumer.
interface blake_round_if #(
  parameter int T_W = 128
);
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [10:0]    in_bits;
  logic           blk_load;
  logic [T_W-1:0] t_out;
  logic           round_ing;
  logic           count_done;
  logic           rdy;
  logic           chain_upd;
  logic           dig_valid;
  logic           dig_ready;
  logic           busy;
  logic           err;

  modport master (
    input  in_valid, in_last, in_bits, count_done, rdy, dig_ready,
    output in_ready, blk_load, t_out, round_ing, chain_upd, dig_valid, busy, err
  );

  modport slave (
    output in_valid, in_last, in_bits, count_done, rdy, dig_ready,
    input  in_ready, blk_load, t_out, round_ing, chain_upd, dig_valid, busy, err
  );
endinterface

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 block controller: takes one message block at a time, runs one 64-step
// round pass, waits for the pipeline result, tracks the bit counter t and presents the digest.
module blake_round_ctrl #(
  parameter int RUN_LEN  = 64,
  parameter int PIPE_LAT = 65,
  parameter int T_W      = 128,
  parameter int TIMEOUT  = 80
) (
  input  logic         clk,
  input  logic         rst,
  blake_round_if.master bus
);

  // The drain limit can never be shorter than the pipeline it is waiting on.
  localparam int TO_LIM = (TIMEOUT > PIPE_LAT) ? TIMEOUT : PIPE_LAT + 1;
  localparam int DW     = $clog2(TO_LIM + 2);
  localparam int SW     = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(RUN_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(TO_LIM);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [T_W-1:0] t_acc_q, t_acc_d;
  logic [T_W-1:0] t_out_q, t_out_d;
  logic           last_r_q, last_r_d;
  logic [SW-1:0]  step_q, step_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           blk_load_q, blk_load_d;
  logic           round_ing_q, round_ing_d;
  logic           chain_upd_q, chain_upd_d;
  logic           dig_valid_q, dig_valid_d;
  logic           err_q, err_d;

  logic           accept;
  logic [T_W-1:0] t_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_acc_q     <= '0;
      t_out_q     <= '0;
      last_r_q    <= 1'b0;
      step_q      <= '0;
      drain_q     <= '0;
      blk_load_q  <= 1'b0;
      round_ing_q <= 1'b0;
      chain_upd_q <= 1'b0;
      dig_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_acc_q     <= t_acc_d;
      t_out_q     <= t_out_d;
      last_r_q    <= last_r_d;
      step_q      <= step_d;
      drain_q     <= drain_d;
      blk_load_q  <= blk_load_d;
      round_ing_q <= round_ing_d;
      chain_upd_q <= chain_upd_d;
      dig_valid_q <= dig_valid_d;
      err_q       <= err_d;
    end
  end

  // A missing count_done on the last step still ends the pass so the FSM cannot hang.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (bus.count_done || step_q == STEP_LAST) state_d = DRAIN;
      DRAIN: begin
        if (bus.rdy)                    state_d = last_r_q ? DONE : IDLE;
        else if (drain_q == DRAIN_LAST) state_d = IDLE;
      end
      DONE:    if (bus.dig_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state_q == IDLE) && bus.in_valid;
    t_sum       = t_acc_q + T_W'(bus.in_bits);
    last_r_d    = accept ? bus.in_last : last_r_q;
    t_acc_d     = t_acc_q;
    t_out_d     = t_out_q;
    if (accept) begin
      t_acc_d = t_sum;
      t_out_d = (bus.in_bits == 11'd0) ? '0 : t_sum;
    end else if (state_q == DONE && bus.dig_ready) begin
      t_acc_d = '0;
    end
    step_d      = (state_q == RUN) ? step_q + 1'b1 : '0;
    drain_d     = (state_q == DRAIN) ? drain_q + 1'b1 : DW'(1);
    blk_load_d  = (state_d == LOAD);
    round_ing_d = (state_d == RUN);
    dig_valid_d = (state_d == DONE);
    chain_upd_d = (state_q == DRAIN) && bus.rdy;
    err_d = err_q
          | (accept && bus.in_bits > 11'd1024)
          | (bus.rdy && state_q != DRAIN)
          | (bus.count_done && state_q != RUN)
          | (state_q == RUN && bus.count_done && step_q != STEP_LAST)
          | (state_q == RUN && !bus.count_done && step_q == STEP_LAST)
          | (state_q == DRAIN && !bus.rdy && drain_q == DRAIN_LAST);
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.blk_load  = blk_load_q;
  assign bus.t_out     = t_out_q;
  assign bus.round_ing = round_ing_q;
  assign bus.chain_upd = chain_upd_q;
  assign bus.dig_valid = dig_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed bench for blake_round_ctrl with a behavioural round counter; a second
// instance with an 11-bit t counter shares all stimulus to expose counter wrap.
module tb_blake_round_ctrl;
  localparam int PIPE_LAT = 65;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blake_round_if #(.T_W(128)) bus ();
  blake_round_if #(.T_W(11))  bus2 ();

  blake_round_ctrl #(.RUN_LEN(64), .PIPE_LAT(PIPE_LAT), .T_W(128), .TIMEOUT(80)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  blake_round_ctrl #(.RUN_LEN(64), .PIPE_LAT(PIPE_LAT), .T_W(11), .TIMEOUT(80)) dut_w (
    .clk(clk), .rst(rst), .bus(bus2));

  assign bus2.in_valid   = bus.in_valid;
  assign bus2.in_last    = bus.in_last;
  assign bus2.in_bits    = bus.in_bits;
  assign bus2.count_done = bus.count_done;
  assign bus2.rdy        = bus.rdy;
  assign bus2.dig_ready  = bus.dig_ready;

  // Round counter model: steps on round_ing, returns rdy PIPE_LAT cycles after count_done.
  logic [5:0] cnt;
  int         rd_cnt;
  logic       rd_arm;
  logic       withhold = 1'b0;
  logic       rdy_force = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 6'd0; rd_arm <= 1'b0; rd_cnt <= 0;
    end else begin
      if (bus.round_ing) cnt <= cnt + 6'd1;
      if (bus.round_ing && bus.count_done) begin
        rd_arm <= 1'b1; rd_cnt <= 1;
      end else if (rd_arm) begin
        if (rd_cnt == PIPE_LAT) rd_arm <= 1'b0;
        else rd_cnt <= rd_cnt + 1;
      end
    end
  end
  assign bus.count_done = (cnt == 6'd63);
  assign bus.rdy = (rd_arm && rd_cnt == PIPE_LAT && !withhold) || rdy_force;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [10:0] bits, input logic last,
                           input logic [127:0] exp_t, input logic [10:0] exp_t2);
    int n;
    bus.in_valid = 1'b1; bus.in_bits = bits; bus.in_last = last;
    cyc();
    bus.in_valid = 1'b0;
    chk("blk_load", 128'(bus.blk_load), 128'(1));
    chk("t_out", bus.t_out, exp_t);
    chk("t_out_w", 128'(bus2.t_out), 128'(exp_t2));
    cyc();
    chk("in_ready_run", 128'(bus.in_ready), 128'(0));
    n = 0;
    while (bus.round_ing === 1'b1 && n < 200) begin n++; cyc(); end
    chk("round_ing_len", 128'(n), 128'(64));
    n = 0;
    while (bus.chain_upd !== 1'b1 && n < 200) begin n++; cyc(); end
    chk("rdy_to_chain", 128'(n), 128'(65));
    chk("dig_valid", 128'(bus.dig_valid), 128'(last));
    chk("in_ready_post", 128'(bus.in_ready), 128'(!last));
  endtask

  task automatic accept_dig();
    bus.dig_ready = 1'b1;
    cyc();
    bus.dig_ready = 1'b0;
    chk("dig_done", 128'(bus.dig_valid), 128'(0));
    chk("idle_ready", 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_bits = 11'd0; bus.dig_ready = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_err", 128'(bus.err), 128'(0));
    chk("rst_round_ing", 128'(bus.round_ing), 128'(0));
    chk("rst_outs", 128'({bus.blk_load, bus.chain_upd, bus.dig_valid}), 128'(0));
    chk("rst_t_out", bus.t_out, 128'(0));
    rst = 1'b0;
    cyc();

    // single final block
    run_block(11'd1024, 1'b1, 128'd1024, 11'd1024);
    accept_dig();

    // two-block message
    run_block(11'd1024, 1'b0, 128'd1024, 11'd1024);
    run_block(11'd512,  1'b1, 128'd1536, 11'd1536);
    accept_dig();

    // padding-only final block
    run_block(11'd1024, 1'b0, 128'd1024, 11'd1024);
    run_block(11'd0,    1'b1, 128'd0,    11'd0);
    chk("t_acc_hold", dut.t_acc_q, 128'd1024);
    accept_dig();

    // narrow counter wraps, digest held under back-pressure
    run_block(11'd1024, 1'b0, 128'd1024, 11'd1024);
    run_block(11'd1024, 1'b0, 128'd2048, 11'd0);
    run_block(11'd1024, 1'b1, 128'd3072, 11'd1024);
    seen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.dig_valid !== 1'b1 || bus.in_ready !== 1'b0) seen = 1'b0;
    end
    chk("dig_hold", 128'(seen), 128'(1));
    accept_dig();
    chk("err_clean", 128'(bus.err), 128'(0));

    // rdy withheld -> timeout
    withhold = 1'b1;
    bus.in_valid = 1'b1; bus.in_bits = 11'd100; bus.in_last = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    n = 0;
    while (bus.round_ing === 1'b1 && n < 200) begin n++; cyc(); end
    chk("to_round_len", 128'(n), 128'(64));
    n = 0; seen = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.chain_upd === 1'b1) seen = 1'b1;
      n++; cyc();
    end
    chk("to_drain_len", 128'(n), 128'(80));
    chk("to_no_chain", 128'({seen, bus.chain_upd}), 128'(0));
    chk("to_err", 128'(bus.err), 128'(1));
    chk("to_idle", 128'({bus.in_ready, bus.dig_valid}), 128'(2));
    withhold = 1'b0;

    // reset mid-run at step 30
    bus.in_valid = 1'b1; bus.in_bits = 11'd1024; bus.in_last = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    for (int i = 0; i < 30; i++) cyc();
    chk("mid_running", 128'(bus.round_ing), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", 128'({bus.round_ing, bus.blk_load, bus.chain_upd, bus.dig_valid, bus.busy, bus.err}), 128'(0));
    chk("mid_rst_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_t", bus.t_out, 128'(0));
    cyc();
    rst = 1'b0;
    cyc();
    run_block(11'd1024, 1'b1, 128'd1024, 11'd1024);
    chk("post_rst_err", 128'(bus.err), 128'(0));
    accept_dig();

    // stray rdy in IDLE
    rdy_force = 1'b1;
    cyc();
    rdy_force = 1'b0;
    chk("stray_rdy_err", 128'(bus.err), 128'(1));
    rst = 1'b1; #1; rst = 1'b0;
    cyc();
    chk("err_cleared", 128'(bus.err), 128'(0));

    // oversize block flags err but still accumulates
    run_block(11'd1100, 1'b1, 128'd1100, 11'd1100);
    chk("oversize_err", 128'(bus.err), 128'(1));
    accept_dig();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
